alu_ctrl_issue: RTL and testbench
=================================

ALU_CTRL_ISSUE -- requirements
Module: alu_ctrl_issue

Interface
REQ-001 SHALL have parameter N, default 32, giving the datapath width of instructions and operands.
REQ-002 SHALL have port clk  input  1  sole clock; all state updates on the rising edge.
REQ-003 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port flush  input  1  synchronous discard of all buffered operations.
REQ-005 SHALL have port in_valid  input  1  upstream offers an instruction.
REQ-006 SHALL have port in_ready  output  1  block accepts; transfer when in_valid & in_ready.
REQ-007 SHALL have port instr  input  N  MIPS instruction word.
REQ-008 SHALL have ports rs_data and rt_data  input  N  register-file read values.
REQ-009 SHALL have port out_valid  output  1  issued op present toward the ALU.
REQ-010 SHALL have port out_ready  input  1  ALU stage consumes; transfer when out_valid & out_ready.
REQ-011 SHALL have port alu_ctrl  output  4  ALU operation code.
REQ-012 SHALL have ports op_a and op_b  output  N  ALU operands (A, B).
REQ-013 SHALL have port illegal  output  1  issued op was undecodable.
REQ-014 SHALL have port illegal_cnt  output  8  saturating count of illegal ops issued.

Function
REQ-015 SHALL decode R-type (opcode 000000) funct: 100000->0010 ADD, 100010->0110 SUB, 100100->0000 AND, 100101->0001 OR, 100111->1100 NOR, 101010->0111 SLT, all with op_a=rs_data, op_b=rt_data.
REQ-016 SHALL decode shifts funct 000000->1000 SLL and 000010->1001 SRL with op_a = zero-extended shamt (instr[10:6]) and op_b = rt_data, because the ALU shifts B by A.
REQ-017 SHALL decode opcode 011100 funct 000010 (MUL)->0011 with rs/rt operands.
REQ-018 SHALL decode I-type: addi 001000, lw 100011, sw 101011->0010 with sign-extended imm; slti 001010->0111 sign-extended; andi 001100->0000 and ori 001101->0001 zero-extended; beq 000100->0110 with op_a=rs_data, op_b=rt_data; op_a=rs_data in every I-type case.
REQ-019 SHALL never issue codes 1011, 1101 or any unlisted code.
REQ-020 SHALL, for any other encoding, issue alu_ctrl=0000, op_a=op_b=0, illegal=1; illegal=0 otherwise.
REQ-021 SHALL register outputs: an op accepted into an empty block appears with out_valid=1 on the next cycle (latency 1).
REQ-022 SHALL contain a main output register plus one skid entry; in_ready SHALL be a registered signal equal to "skid entry empty".
REQ-023 SHALL, when the output is held (out_valid & ~out_ready) and an input is accepted, store the input in the skid entry; the skid entry SHALL move to the output register on the next output transfer.
REQ-024 SHALL hold alu_ctrl, op_a, op_b and illegal stable while out_valid & ~out_ready.
REQ-025 SHALL preserve issue order; no op SHALL be dropped or duplicated except under flush.
REQ-026 SHALL treat simultaneous output transfer and input accept with an empty skid entry as pass-through: the new op enters the output register and the skid entry stays empty.
REQ-027 SHALL, on flush, empty both entries at the next edge: out_valid=0 and in_ready=1 on the following cycle, and any input offered during the flush cycle is discarded.
REQ-028 SHALL increment illegal_cnt by one on each output transfer with illegal=1, saturating at 255; flush SHALL NOT clear it.

Reset
REQ-029 SHALL, while rst_n=0, force out_valid=0, in_ready=0, alu_ctrl=0000, op_a=op_b=0, illegal=0, illegal_cnt=0, and empty the skid entry, asynchronously.
REQ-030 SHALL drive in_ready=1 from the first rising edge after rst_n deasserts; operations in flight at reset are lost.

Structure
REQ-031 SHALL take ALU control codes, opcode and funct constants from a shared package, mips_alu_pkg.
REQ-032 SHALL place the purely combinational decode in one sub-module, alu_ctrl_decode, instantiated once on the input side, before the buffer.

Verification
REQ-033 SHALL cover: add $3,$1,$2 with rs=5, rt=7, out_ready=1 -> next cycle out_valid=1, alu_ctrl=0010, op_a=5, op_b=7.
REQ-034 SHALL cover: sll shamt=4, rt=0x1 -> alu_ctrl=1000, op_a=4, op_b=0x1; slti imm=0xFFFF -> op_b=0xFFFFFFFF; andi imm=0xFFFF -> op_b=0x0000FFFF.
REQ-035 SHALL cover: out_ready=0 while 2 ops are sent -> second op goes to skid, in_ready=0; raise out_ready -> both ops issue in order over consecutive cycles, in_ready back to 1.
REQ-036 SHALL cover: flush with both entries full -> out_valid=0 and in_ready=1 the next cycle; an op offered in the flush cycle never issues.
REQ-037 SHALL cover: 260 illegal words (opcode 111111) issued -> illegal=1, alu_ctrl=0000, illegal_cnt=255 stuck.
REQ-038 SHALL cover: rst_n asserted mid-stall -> all outputs zero immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/mips_alu_pkg.sv
// mips_alu_pkg: the ALU control codes, MIPS opcode/funct constants and
// operand-select encoding shared by the decoder and the issue buffer.
package mips_alu_pkg;

   // ALU operation codes driven on alu_ctrl
   localparam logic [3:0] ALU_AND     = 4'b0000;
   localparam logic [3:0] ALU_OR      = 4'b0001;
   localparam logic [3:0] ALU_ADD     = 4'b0010;
   localparam logic [3:0] ALU_MUL     = 4'b0011;
   localparam logic [3:0] ALU_SUB     = 4'b0110;
   localparam logic [3:0] ALU_SLT     = 4'b0111;
   localparam logic [3:0] ALU_SLL     = 4'b1000;
   localparam logic [3:0] ALU_SRL     = 4'b1001;
   localparam logic [3:0] ALU_NOR     = 4'b1100;
   localparam logic [3:0] ALU_ILLEGAL = 4'b0000;

   // Primary opcodes (instr[31:26])
   localparam logic [5:0] OP_RTYPE    = 6'b000000;
   localparam logic [5:0] OP_SPECIAL2 = 6'b011100;
   localparam logic [5:0] OP_BEQ      = 6'b000100;
   localparam logic [5:0] OP_ADDI     = 6'b001000;
   localparam logic [5:0] OP_SLTI     = 6'b001010;
   localparam logic [5:0] OP_ANDI     = 6'b001100;
   localparam logic [5:0] OP_ORI      = 6'b001101;
   localparam logic [5:0] OP_LW       = 6'b100011;
   localparam logic [5:0] OP_SW       = 6'b101011;

   // Function codes (instr[5:0])
   localparam logic [5:0] F_SLL = 6'b000000;
   localparam logic [5:0] F_SRL = 6'b000010;
   localparam logic [5:0] F_ADD = 6'b100000;
   localparam logic [5:0] F_SUB = 6'b100010;
   localparam logic [5:0] F_AND = 6'b100100;
   localparam logic [5:0] F_OR  = 6'b100101;
   localparam logic [5:0] F_NOR = 6'b100111;
   localparam logic [5:0] F_SLT = 6'b101010;
   localparam logic [5:0] F_MUL = 6'b000010;   // under OP_SPECIAL2

   localparam logic [7:0] ILL_CNT_MAX = 8'd255;

   // How the decoder builds op_a / op_b
   typedef enum logic [2:0] {
      SEL_ZERO,    // both operands zero (undecodable)
      SEL_RR,      // A = rs, B = rt
      SEL_SHAMT,   // A = zero-extended shamt, B = rt
      SEL_SIMM,    // A = rs, B = sign-extended imm
      SEL_ZIMM     // A = rs, B = zero-extended imm
   } opsel_e;

endpackage

// File: rtl/alu_ctrl_decode.sv
// alu_ctrl_decode: purely combinational MIPS instruction -> ALU control and
// operand decode.
//   instr            : instruction word
//   rs_data, rt_data : register-file read values
//   alu_ctrl         : ALU operation code
//   op_a, op_b       : ALU operands
//   illegal          : instruction is not one of the supported encodings
module alu_ctrl_decode
   import mips_alu_pkg::*;
#(
   parameter int N = 32
) (
   input  logic [N-1:0] instr,
   input  logic [N-1:0] rs_data,
   input  logic [N-1:0] rt_data,
   output logic [3:0]   alu_ctrl,
   output logic [N-1:0] op_a,
   output logic [N-1:0] op_b,
   output logic         illegal
);

   logic [5:0] opcode;
   logic [5:0] funct;
   logic [4:0] shamt;
   logic [15:0] imm;
   opsel_e     sel;
   // Register-number fields are resolved upstream; only their data is used.
   logic       unused_fields;

   assign opcode        = instr[31:26];
   assign funct         = instr[5:0];
   assign shamt         = instr[10:6];
   assign imm           = instr[15:0];
   assign unused_fields = ^instr[25:16];

   always_comb begin
      alu_ctrl = ALU_ILLEGAL;
      sel      = SEL_ZERO;
      illegal  = 1'b1;
      case (opcode)
         OP_RTYPE: begin
            illegal = 1'b0;
            sel     = SEL_RR;
            case (funct)
               F_ADD: alu_ctrl = ALU_ADD;
               F_SUB: alu_ctrl = ALU_SUB;
               F_AND: alu_ctrl = ALU_AND;
               F_OR:  alu_ctrl = ALU_OR;
               F_NOR: alu_ctrl = ALU_NOR;
               F_SLT: alu_ctrl = ALU_SLT;
               // The ALU shifts B by A, so the shift amount rides on A.
               F_SLL: begin alu_ctrl = ALU_SLL; sel = SEL_SHAMT; end
               F_SRL: begin alu_ctrl = ALU_SRL; sel = SEL_SHAMT; end
               default: begin
                  alu_ctrl = ALU_ILLEGAL;
                  sel      = SEL_ZERO;
                  illegal  = 1'b1;
               end
            endcase
         end
         OP_SPECIAL2: begin
            if (funct == F_MUL) begin
               alu_ctrl = ALU_MUL;
               sel      = SEL_RR;
               illegal  = 1'b0;
            end
         end
         OP_ADDI, OP_LW, OP_SW: begin alu_ctrl = ALU_ADD; sel = SEL_SIMM; illegal = 1'b0; end
         OP_SLTI: begin alu_ctrl = ALU_SLT; sel = SEL_SIMM; illegal = 1'b0; end
         OP_ANDI: begin alu_ctrl = ALU_AND; sel = SEL_ZIMM; illegal = 1'b0; end
         OP_ORI:  begin alu_ctrl = ALU_OR;  sel = SEL_ZIMM; illegal = 1'b0; end
         OP_BEQ:  begin alu_ctrl = ALU_SUB; sel = SEL_RR;   illegal = 1'b0; end
         default: ;
      endcase
   end

   always_comb begin
      op_a = '0;
      op_b = '0;
      case (sel)
         SEL_RR:    begin op_a = rs_data; op_b = rt_data; end
         SEL_SHAMT: begin op_a = {{(N-5){1'b0}}, shamt}; op_b = rt_data; end
         SEL_SIMM:  begin op_a = rs_data; op_b = {{(N-16){imm[15]}}, imm}; end
         SEL_ZIMM:  begin op_a = rs_data; op_b = {{(N-16){1'b0}}, imm}; end
         default:   ;
      endcase
   end

endmodule

// File: rtl/alu_ctrl_issue.sv
// alu_ctrl_issue: decodes MIPS instructions and issues ALU operations through
// a registered output stage with one skid entry (valid/ready on both sides).
//   clk, rst_n           : clock, asynchronous active-low reset
//   flush                : discard everything buffered at the next edge
//   in_valid/in_ready    : upstream handshake; instr, rs_data, rt_data payload
//   out_valid/out_ready  : ALU-side handshake
//   alu_ctrl, op_a, op_b : issued operation
//   illegal              : issued op was undecodable
//   illegal_cnt          : saturating count of illegal ops transferred
module alu_ctrl_issue
   import mips_alu_pkg::*;
#(
   parameter int N = 32
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         flush,
   input  logic         in_valid,
   output logic         in_ready,
   input  logic [N-1:0] instr,
   input  logic [N-1:0] rs_data,
   input  logic [N-1:0] rt_data,
   output logic         out_valid,
   input  logic         out_ready,
   output logic [3:0]   alu_ctrl,
   output logic [N-1:0] op_a,
   output logic [N-1:0] op_b,
   output logic         illegal,
   output logic [7:0]   illegal_cnt
);

   logic [3:0]   dec_ctrl;
   logic [N-1:0] dec_a, dec_b;
   logic         dec_ill;

   alu_ctrl_decode #(.N(N)) u_decode (
      .instr    (instr),
      .rs_data  (rs_data),
      .rt_data  (rt_data),
      .alu_ctrl (dec_ctrl),
      .op_a     (dec_a),
      .op_b     (dec_b),
      .illegal  (dec_ill)
   );

   logic         out_valid_q, out_valid_d;
   logic [3:0]   out_ctrl_q, out_ctrl_d;
   logic [N-1:0] out_a_q, out_a_d, out_b_q, out_b_d;
   logic         out_ill_q, out_ill_d;
   logic         skid_valid_q, skid_valid_d;
   logic [3:0]   skid_ctrl_q, skid_ctrl_d;
   logic [N-1:0] skid_a_q, skid_a_d, skid_b_q, skid_b_d;
   logic         skid_ill_q, skid_ill_d;
   logic         in_ready_q, in_ready_d;
   logic [7:0]   ill_cnt_q, ill_cnt_d;

   logic accept, out_xfer;

   assign accept   = in_valid & in_ready_q;
   assign out_xfer = out_valid_q & out_ready;

   always_comb begin
      out_valid_d  = out_valid_q;
      out_ctrl_d   = out_ctrl_q;
      out_a_d      = out_a_q;
      out_b_d      = out_b_q;
      out_ill_d    = out_ill_q;
      skid_valid_d = skid_valid_q;
      skid_ctrl_d  = skid_ctrl_q;
      skid_a_d     = skid_a_q;
      skid_b_d     = skid_b_q;
      skid_ill_d   = skid_ill_q;
      ill_cnt_d    = ill_cnt_q;

      if (out_xfer && out_ill_q && (ill_cnt_q != ILL_CNT_MAX))
         ill_cnt_d = ill_cnt_q + 8'd1;

      if (flush) begin
         out_valid_d  = 1'b0;
         skid_valid_d = 1'b0;
      end else if (!out_valid_q || out_ready) begin
         // Output register frees up this cycle. in_ready_q is low whenever
         // the skid entry is occupied, so a skid refill and a new accept
         // cannot coincide.
         if (skid_valid_q) begin
            out_valid_d  = 1'b1;
            out_ctrl_d   = skid_ctrl_q;
            out_a_d      = skid_a_q;
            out_b_d      = skid_b_q;
            out_ill_d    = skid_ill_q;
            skid_valid_d = 1'b0;
         end else begin
            out_valid_d = accept;
            if (accept) begin
               out_ctrl_d = dec_ctrl;
               out_a_d    = dec_a;
               out_b_d    = dec_b;
               out_ill_d  = dec_ill;
            end
         end
      end else if (accept) begin
         // Output is stalled: park the new op behind it.
         skid_valid_d = 1'b1;
         skid_ctrl_d  = dec_ctrl;
         skid_a_d     = dec_a;
         skid_b_d     = dec_b;
         skid_ill_d   = dec_ill;
      end

      in_ready_d = ~skid_valid_d;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_valid_q  <= 1'b0;
         out_ctrl_q   <= ALU_ILLEGAL;
         out_a_q      <= '0;
         out_b_q      <= '0;
         out_ill_q    <= 1'b0;
         skid_valid_q <= 1'b0;
         skid_ctrl_q  <= ALU_ILLEGAL;
         skid_a_q     <= '0;
         skid_b_q     <= '0;
         skid_ill_q   <= 1'b0;
         in_ready_q   <= 1'b0;
         ill_cnt_q    <= 8'd0;
      end else begin
         out_valid_q  <= out_valid_d;
         out_ctrl_q   <= out_ctrl_d;
         out_a_q      <= out_a_d;
         out_b_q      <= out_b_d;
         out_ill_q    <= out_ill_d;
         skid_valid_q <= skid_valid_d;
         skid_ctrl_q  <= skid_ctrl_d;
         skid_a_q     <= skid_a_d;
         skid_b_q     <= skid_b_d;
         skid_ill_q   <= skid_ill_d;
         in_ready_q   <= in_ready_d;
         ill_cnt_q    <= ill_cnt_d;
      end
   end

   assign in_ready    = in_ready_q;
   assign out_valid   = out_valid_q;
   assign alu_ctrl    = out_ctrl_q;
   assign op_a        = out_a_q;
   assign op_b        = out_b_q;
   assign illegal     = out_ill_q;
   assign illegal_cnt = ill_cnt_q;

endmodule

// File: tb/tb_alu_ctrl_issue.sv
// tb_alu_ctrl_issue: directed self-checking bench for alu_ctrl_issue.
module tb_alu_ctrl_issue;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        flush;
   logic        in_valid;
   logic        in_ready;
   logic [31:0] instr, rs_data, rt_data;
   logic        out_valid;
   logic        out_ready;
   logic [3:0]  alu_ctrl;
   logic [31:0] op_a, op_b;
   logic        illegal;
   logic [7:0]  illegal_cnt;

   int checks = 0;
   int errors = 0;

   alu_ctrl_issue #(.N(32)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .flush       (flush),
      .in_valid    (in_valid),
      .in_ready    (in_ready),
      .instr       (instr),
      .rs_data     (rs_data),
      .rt_data     (rt_data),
      .out_valid   (out_valid),
      .out_ready   (out_ready),
      .alu_ctrl    (alu_ctrl),
      .op_a        (op_a),
      .op_b        (op_b),
      .illegal     (illegal),
      .illegal_cnt (illegal_cnt)
   );

   always #5 clk = ~clk;

   // Decode vectors: instr, rs, rt, expected ctrl, A, B, illegal
   localparam int NV = 16;
   logic [31:0] v_instr [NV] = '{
      32'h00221820, 32'h00011100, 32'h000117C2, 32'h2822FFFF,
      32'h3022FFFF, 32'h34228001, 32'h8C228000, 32'h10220003,
      32'h70221802, 32'h00221827, 32'h0022182A, 32'h00221803,
      32'h00221825, 32'h00221824, 32'hAC220004, 32'h20227FFF};
   logic [31:0] v_rs [NV] = '{
      32'd5, 32'h0000AAAA, 32'd3, 32'd9, 32'd10, 32'd11, 32'd12, 32'd13,
      32'd14, 32'd15, 32'd16, 32'd17, 32'd18, 32'd19, 32'd20, 32'd21};
   logic [31:0] v_rt [NV] = '{
      32'd7, 32'h1, 32'h80000000, 32'd40, 32'd41, 32'd42, 32'd43, 32'd44,
      32'd45, 32'd46, 32'd47, 32'd48, 32'd49, 32'd50, 32'd51, 32'd52};
   logic [3:0] v_ctrl [NV] = '{
      4'b0010, 4'b1000, 4'b1001, 4'b0111, 4'b0000, 4'b0001, 4'b0010, 4'b0110,
      4'b0011, 4'b1100, 4'b0111, 4'b0000, 4'b0001, 4'b0000, 4'b0010, 4'b0010};
   logic [31:0] v_a [NV] = '{
      32'd5, 32'd4, 32'd31, 32'd9, 32'd10, 32'd11, 32'd12, 32'd13,
      32'd14, 32'd15, 32'd16, 32'd0, 32'd18, 32'd19, 32'd20, 32'd21};
   logic [31:0] v_b [NV] = '{
      32'd7, 32'h1, 32'h80000000, 32'hFFFFFFFF, 32'h0000FFFF, 32'h00008001,
      32'hFFFF8000, 32'd44, 32'd45, 32'd46, 32'd47, 32'd0, 32'd49, 32'd50,
      32'd4, 32'h00007FFF};
   logic v_ill [NV] = '{
      1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0,
      1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic [31:0] i, input logic [31:0] rs, input logic [31:0] rt);
      in_valid = 1'b1;
      instr    = i;
      rs_data  = rs;
      rt_data  = rt;
   endtask

   task automatic test_reset();
      rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
      instr = '0; rs_data = '0; rt_data = '0;
      #3;
      checks++;
      if ({out_valid, in_ready, alu_ctrl, op_a, op_b, illegal, illegal_cnt} !== 79'd0) begin
         errors++;
         $display("FAIL reset_outputs got v=%0b r=%0b c=%b a=%h b=%h i=%0b n=%0d exp all zero",
                  out_valid, in_ready, alu_ctrl, op_a, op_b, illegal, illegal_cnt);
      end
      @(negedge clk);
      rst_n = 1'b1;
      #1;
      checks++;
      if (in_ready !== 1'b0) begin
         errors++; $display("FAIL ready_before_edge got %0b exp 0", in_ready);
      end
      step();
      checks++;
      if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
         errors++; $display("FAIL ready_after_edge got r=%0b v=%0b exp r=1 v=0", in_ready, out_valid);
      end
      $display("reset: done");
   endtask

   // Back-to-back stream through the decoder with out_ready held high.
   task automatic test_decode_stream();
      logic [69:0] got, exp;
      out_ready = 1'b1;
      for (int i = 0; i < NV; i++) begin
         drive(v_instr[i], v_rs[i], v_rt[i]);
         step();
         got = {out_valid, alu_ctrl, op_a, op_b, illegal};
         exp = {1'b1, v_ctrl[i], v_a[i], v_b[i], v_ill[i]};
         checks++;
         if (got !== exp || in_ready !== 1'b1) begin
            errors++;
            $display("FAIL decode_%0d instr=%h got v=%0b c=%b a=%h b=%h i=%0b r=%0b exp c=%b a=%h b=%h i=%0b",
                     i, v_instr[i], out_valid, alu_ctrl, op_a, op_b, illegal, in_ready,
                     v_ctrl[i], v_a[i], v_b[i], v_ill[i]);
         end
         $display("decode: instr=%h ctrl=%b a=%h b=%h ill=%0b", v_instr[i], alu_ctrl, op_a, op_b, illegal);
      end
      in_valid = 1'b0;
      step();
      checks++;
      if (out_valid !== 1'b0 || illegal_cnt !== 8'd1) begin
         errors++; $display("FAIL decode_drain got v=%0b cnt=%0d exp v=0 cnt=1", out_valid, illegal_cnt);
      end
   endtask

   task automatic test_skid();
      out_ready = 1'b0;
      drive(32'h00221820, 32'd11, 32'd22);       // add
      step();
      drive(32'h00221822, 32'd33, 32'd44);       // sub
      step();
      in_valid = 1'b0;
      checks++;
      if (out_valid !== 1'b1 || in_ready !== 1'b0 || alu_ctrl !== 4'b0010 || op_a !== 32'd11 || op_b !== 32'd22) begin
         errors++;
         $display("FAIL skid_fill got v=%0b r=%0b c=%b a=%h b=%h exp v=1 r=0 c=0010 a=b b=16",
                  out_valid, in_ready, alu_ctrl, op_a, op_b);
      end
      step();
      checks++;
      if (alu_ctrl !== 4'b0010 || op_a !== 32'd11 || op_b !== 32'd22 || out_valid !== 1'b1) begin
         errors++; $display("FAIL skid_hold got c=%b a=%h b=%h exp c=0010 a=b b=16", alu_ctrl, op_a, op_b);
      end
      out_ready = 1'b1;
      step();
      checks++;
      if (out_valid !== 1'b1 || alu_ctrl !== 4'b0110 || op_a !== 32'd33 || op_b !== 32'd44 || in_ready !== 1'b1) begin
         errors++;
         $display("FAIL skid_second got v=%0b c=%b a=%h b=%h r=%0b exp v=1 c=0110 a=21 b=2c r=1",
                  out_valid, alu_ctrl, op_a, op_b, in_ready);
      end
      step();
      checks++;
      if (out_valid !== 1'b0) begin
         errors++; $display("FAIL skid_empty got v=%0b exp 0", out_valid);
      end
      $display("skid: two ops issued in order");
   endtask

   task automatic test_flush();
      // Both entries full, op offered during flush.
      out_ready = 1'b0;
      drive(32'h00221820, 32'd1, 32'd2); step();
      drive(32'h00221822, 32'd3, 32'd4); step();
      flush = 1'b1;
      drive(32'h00221825, 32'd5, 32'd6);
      step();
      flush = 1'b0; in_valid = 1'b0;
      checks++;
      if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
         errors++; $display("FAIL flush_full got v=%0b r=%0b exp v=0 r=1", out_valid, in_ready);
      end
      out_ready = 1'b1;
      step(); step();
      checks++;
      if (out_valid !== 1'b0) begin
         errors++; $display("FAIL flush_full_drain got v=%0b exp 0", out_valid);
      end
      // One entry full, op offered while in_ready=1 during flush.
      out_ready = 1'b0;
      drive(32'h00221820, 32'd7, 32'd8); step();
      flush = 1'b1;
      drive(32'h00221825, 32'd9, 32'd10);
      step();
      flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
      checks++;
      if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
         errors++; $display("FAIL flush_one got v=%0b r=%0b exp v=0 r=1", out_valid, in_ready);
      end
      step();
      checks++;
      if (out_valid !== 1'b0) begin
         errors++; $display("FAIL flush_discard got v=%0b c=%b a=%h exp v=0", out_valid, alu_ctrl, op_a);
      end
      $display("flush: buffered and offered ops discarded");
   endtask

   // illegal_cnt is 1 entering this test (one illegal op in the decode stream).
   // Edge k of the stream completes transfer k-1, so the count equals k until it saturates.
   task automatic test_illegal_sat();
      out_ready = 1'b1;
      drive(32'hFC000000, 32'h1234, 32'h5678);
      for (int k = 1; k <= 260; k++) begin
         step();
         if (k == 1) begin
            checks++;
            if (out_valid !== 1'b1 || illegal !== 1'b1 || alu_ctrl !== 4'b0000 || op_a !== 32'd0 || op_b !== 32'd0) begin
               errors++;
               $display("FAIL illegal_out got v=%0b i=%0b c=%b a=%h b=%h exp v=1 i=1 c=0000 a=0 b=0",
                        out_valid, illegal, alu_ctrl, op_a, op_b);
            end
         end
         if (k == 10 || k == 254 || k == 255 || k == 258) begin
            checks++;
            if (illegal_cnt !== ((k > 255) ? 8'd255 : 8'(k))) begin
               errors++; $display("FAIL illegal_cnt_k%0d got %0d exp %0d", k, illegal_cnt, (k > 255) ? 255 : k);
            end
         end
      end
      in_valid = 1'b0;
      step(); step();
      checks++;
      if (illegal_cnt !== 8'd255 || out_valid !== 1'b0) begin
         errors++; $display("FAIL illegal_sat got cnt=%0d v=%0b exp cnt=255 v=0", illegal_cnt, out_valid);
      end
      flush = 1'b1; step(); flush = 1'b0;
      checks++;
      if (illegal_cnt !== 8'd255) begin
         errors++; $display("FAIL illegal_flush_keep got %0d exp 255", illegal_cnt);
      end
      $display("illegal: count=%0d", illegal_cnt);
   endtask

   task automatic test_async_reset();
      out_ready = 1'b0;
      drive(32'h00221820, 32'd100, 32'd200); step();
      drive(32'h00221822, 32'd300, 32'd400); step();
      in_valid = 1'b0;
      @(negedge clk);
      rst_n = 1'b0;
      #1;
      checks++;
      if ({out_valid, in_ready, alu_ctrl, op_a, op_b, illegal, illegal_cnt} !== 79'd0) begin
         errors++;
         $display("FAIL async_reset got v=%0b r=%0b c=%b a=%h b=%h i=%0b n=%0d exp all zero",
                  out_valid, in_ready, alu_ctrl, op_a, op_b, illegal, illegal_cnt);
      end
      @(negedge clk);
      rst_n = 1'b1;
      out_ready = 1'b1;
      step();
      checks++;
      if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
         errors++; $display("FAIL post_reset got r=%0b v=%0b exp r=1 v=0", in_ready, out_valid);
      end
      step();
      checks++;
      if (out_valid !== 1'b0) begin
         errors++; $display("FAIL post_reset_skid got v=%0b exp 0", out_valid);
      end
      $display("async_reset: outputs cleared without a clock edge");
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog expired");
      $fatal(1, "watchdog");
   end

   initial begin
      test_reset();
      test_decode_stream();
      test_skid();
      test_flush();
      test_illegal_sat();
      test_async_reset();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
